// File: rtl/assert_ctrl_pkg.sv
// assert_ctrl_pkg: shared types for the assertion-control sequencer.
// Ctrl codes, type bit positions, command bundle and FSM states.
package assert_ctrl_pkg;

  localparam int NUM_CHK_DEF = 16;
  localparam int SEL_W       = $clog2(NUM_CHK_DEF);

  typedef enum logic [3:0] {
    CTRL_LOCK       = 4'd1,
    CTRL_UNLOCK     = 4'd2,
    CTRL_ON         = 4'd3,
    CTRL_OFF        = 4'd4,
    CTRL_KILL       = 4'd5,
    CTRL_VACUOUSON  = 4'd10,
    CTRL_VACUOUSOFF = 4'd11
  } ctrl_e;

  localparam int AT_CONCURRENT = 0;
  localparam int AT_S_IMM      = 1;
  localparam int AT_D_IMM_OBS  = 2;
  localparam int AT_D_IMM_FIN  = 3;
  localparam int AT_EXPECT     = 4;
  localparam int AT_UNIQUE     = 5;
  localparam int AT_UNIQUE0    = 6;
  localparam int AT_PRIORITY   = 7;

  localparam int DT_ASSERT = 0;
  localparam int DT_COVER  = 1;
  localparam int DT_ASSUME = 2;

  typedef struct packed {
    logic [3:0]       ctrl;
    logic [7:0]       amask;
    logic [2:0]       dmask;
    logic             sel_all;
    logic [SEL_W-1:0] sel_id;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SWEEP,
    S_SINGLE,
    S_DONE
  } state_e;

  function automatic logic ctrl_legal(input logic [3:0] c);
    return c inside {CTRL_LOCK, CTRL_UNLOCK, CTRL_ON, CTRL_OFF,
                     CTRL_KILL, CTRL_VACUOUSON, CTRL_VACUOUSOFF};
  endfunction

  // Commands that a lock blocks; LOCK/UNLOCK always go through.
  function automatic logic ctrl_gated(input logic [3:0] c);
    return c inside {CTRL_ON, CTRL_OFF, CTRL_KILL,
                     CTRL_VACUOUSON, CTRL_VACUOUSOFF};
  endfunction

endpackage

// File: rtl/assert_ctrl_seq_cmd_fifo.sv
// assert_ctrl_cmd_fifo: small synchronous command FIFO.
// Wrap-bit pointers; push ignored when full, pop ignored when empty.
module assert_ctrl_cmd_fifo
  import assert_ctrl_pkg::*;
#(
  parameter int W     = $bits(cmd_t),
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_ok, pop_ok;

  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // Pointer advance.
  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, push_ok};
    rd_d = rd_q + {{AW{1'b0}}, pop_ok};
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/assert_ctrl_seq.sv
// assert_ctrl_seq: queues assertion-control commands and applies them per slot.
// Define ASSERT_CTRL_LOCK_STATS_EN to count lock-suppressed slot updates.
module assert_ctrl_seq
  import assert_ctrl_pkg::*;
#(
  parameter int  NUM_CHK    = 16,
  parameter int  FIFO_DEPTH = 4,
  localparam int ID_W       = $clog2(NUM_CHK)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  cmd_t                 cmd_i,
  input  logic [NUM_CHK*8-1:0] chk_atype_i,
  input  logic [NUM_CHK*3-1:0] chk_dtype_i,
  output logic [NUM_CHK-1:0]   chk_en_o,
  output logic [NUM_CHK-1:0]   chk_vac_off_o,
  output logic [NUM_CHK-1:0]   chk_kill_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [15:0]          lock_skip_o
);

  localparam int CMD_W = $bits(cmd_t);

  state_e             state_q, state_d;
  cmd_t               cmd_q, cmd_d, head;
  logic [ID_W-1:0]    idx_q, idx_d;
  logic               err_q, err_d;
  logic [NUM_CHK-1:0] en_q, en_d, vac_q, vac_d;
  logic [NUM_CHK-1:0] lock_q, lock_d, kill_q, kill_d;
  logic [CMD_W-1:0]   fifo_dout;
  logic               fifo_full, fifo_empty, pop, visit, skip;

  assert_ctrl_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid_i),
    .pop_i   (pop),
    .din_i   (cmd_i),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head          = cmd_t'(fifo_dout);
  assign pop           = (state_q == S_FETCH);
  assign cmd_ready_o   = !fifo_full;
  assign busy_o        = (state_q != S_IDLE) || !fifo_empty;
  assign done_o        = (state_q == S_DONE);
  assign err_o         = done_o && err_q;
  assign chk_en_o      = en_q;
  assign chk_vac_off_o = vac_q;
  assign chk_kill_o    = kill_q;

  // Sequencer: fetch/decode, then visit one slot per cycle.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    err_d   = err_q;
    visit   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) state_d = S_FETCH;
      end
      S_FETCH: begin
        cmd_d = head;
        idx_d = '0;
        err_d = 1'b0;
        if (!ctrl_legal(head.ctrl) ||
            (!head.sel_all && int'(head.sel_id) >= NUM_CHK)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (head.sel_all) begin
          state_d = S_SWEEP;
        end else begin
          idx_d   = ID_W'(head.sel_id);
          state_d = S_SINGLE;
        end
      end
      S_SWEEP: begin
        visit = 1'b1;
        if (idx_q == ID_W'(NUM_CHK - 1)) state_d = S_DONE;
        else idx_d = idx_q + 1'b1;
      end
      S_SINGLE: begin
        visit   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = fifo_empty ? S_IDLE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Apply the current command to the visited slot if its types match.
  always_comb begin
    en_d   = en_q;
    vac_d  = vac_q;
    lock_d = lock_q;
    kill_d = '0;
    skip   = 1'b0;
    for (int i = 0; i < NUM_CHK; i++) begin
      if (visit && idx_q == ID_W'(i) &&
          |(chk_atype_i[i*8 +: 8] & cmd_q.amask) &&
          |(chk_dtype_i[i*3 +: 3] & cmd_q.dmask)) begin
        if (ctrl_gated(cmd_q.ctrl) && lock_q[i]) begin
          skip = 1'b1;
        end else begin
          case (cmd_q.ctrl)
            CTRL_LOCK:       lock_d[i] = 1'b1;
            CTRL_UNLOCK:     lock_d[i] = 1'b0;
            CTRL_ON:         en_d[i]   = 1'b1;
            CTRL_OFF:        en_d[i]   = 1'b0;
            CTRL_KILL:       kill_d[i] = 1'b1;
            CTRL_VACUOUSON:  vac_d[i]  = 1'b0;
            CTRL_VACUOUSOFF: vac_d[i]  = 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  // State and per-slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      en_q    <= '1;
      vac_q   <= '0;
      lock_q  <= '0;
      kill_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      en_q    <= en_d;
      vac_q   <= vac_d;
      lock_q  <= lock_d;
      kill_q  <= kill_d;
    end
  end

`ifdef ASSERT_CTRL_LOCK_STATS_EN
  logic [15:0] skip_cnt_q, skip_cnt_d;

  // Saturating count of lock-suppressed slot visits.
  always_comb begin
    skip_cnt_d = skip_cnt_q;
    if (skip && skip_cnt_q != 16'hFFFF) skip_cnt_d = skip_cnt_q + 16'd1;
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) skip_cnt_q <= '0;
    else     skip_cnt_q <= skip_cnt_d;
  end

  assign lock_skip_o = skip_cnt_q;
`else
  logic unused_skip;
  assign unused_skip = skip;
  assign lock_skip_o = '0;
`endif

endmodule

// File: tb/tb_assert_ctrl_seq.sv
// tb_assert_ctrl_seq: directed bench for assert_ctrl_seq.
// Twelve slots with a fixed mix of assertion and directive types.
module tb_assert_ctrl_seq;
  import assert_ctrl_pkg::*;

  localparam int N = 12;

`ifdef ASSERT_CTRL_LOCK_STATS_EN
  localparam logic [15:0] SKIP_ONE = 16'd1;
`else
  localparam logic [15:0] SKIP_ONE = 16'd0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid_i;
  logic           cmd_ready_o;
  cmd_t           cmd_i;
  logic [N*8-1:0] chk_atype_i;
  logic [N*3-1:0] chk_dtype_i;
  logic [N-1:0]   chk_en_o, chk_vac_off_o, chk_kill_o;
  logic           busy_o, done_o, err_o;
  logic [15:0]    lock_skip_o;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] kill_acc;
  int           kill_cnt;
  int           lat;
  logic         tmo;

  assert_ctrl_seq #(.NUM_CHK(N), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_i         (cmd_i),
    .chk_atype_i   (chk_atype_i),
    .chk_dtype_i   (chk_dtype_i),
    .chk_en_o      (chk_en_o),
    .chk_vac_off_o (chk_vac_off_o),
    .chk_kill_o    (chk_kill_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .lock_skip_o   (lock_skip_o)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [3:0] c, input logic [7:0] am,
                      input logic [2:0] dm, input logic all,
                      input logic [3:0] id);
    @(negedge clk);
    cmd_i.ctrl    = c;
    cmd_i.amask   = am;
    cmd_i.dmask   = dm;
    cmd_i.sel_all = all;
    cmd_i.sel_id  = id;
    cmd_valid_i   = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  // Cycles counted with the push cycle as cycle 0; returns in the done cycle.
  task automatic wait_done(output int l, output logic to);
    l        = 1;
    to       = 1'b1;
    kill_acc = chk_kill_o;
    kill_cnt = $countones(chk_kill_o);
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      l++;
      kill_acc |= chk_kill_o;
      kill_cnt += $countones(chk_kill_o);
      if (done_o) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if (chk_en_o !== 12'hFFF) begin
      errors++; $display("FAIL rst_en got=%h exp=fff", chk_en_o);
    end
    checks++;
    if (chk_vac_off_o !== 12'h000) begin
      errors++; $display("FAIL rst_vac got=%h exp=000", chk_vac_off_o);
    end
    checks++;
    if (chk_kill_o !== 12'h000) begin
      errors++; $display("FAIL rst_kill got=%h exp=000", chk_kill_o);
    end
    checks++;
    if ({busy_o, done_o, err_o} !== 3'b000) begin
      errors++; $display("FAIL rst_flags got=%b exp=000", {busy_o, done_o, err_o});
    end
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL rst_ready got=%b exp=1", cmd_ready_o);
    end
    checks++;
    if (lock_skip_o !== 16'd0) begin
      errors++; $display("FAIL rst_skip got=%0d exp=0", lock_skip_o);
    end
  endtask

  task automatic test_off_all;
    push(CTRL_OFF, 8'hFF, 3'b111, 1'b1, 4'd0);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL off_busy got=%b exp=1", busy_o);
    end
    wait_done(lat, tmo);
    checks++;
    if (tmo || lat != N + 3) begin
      errors++; $display("FAIL off_latency got=%0d tmo=%b exp=%0d", lat, tmo, N + 3);
    end
    checks++;
    if (chk_en_o !== 12'h000) begin
      errors++; $display("FAIL off_en got=%h exp=000", chk_en_o);
    end
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL off_err got=%b exp=0", err_o);
    end
  endtask

  task automatic test_lock;
    push(CTRL_LOCK, 8'h01, 3'b001, 1'b0, 4'd2);
    wait_done(lat, tmo);
    checks++;
    if (tmo || lat != 4) begin
      errors++; $display("FAIL lock_latency got=%0d tmo=%b exp=4", lat, tmo);
    end
    push(CTRL_ON, 8'hFF, 3'b111, 1'b1, 4'd0);
    wait_done(lat, tmo);
    checks++;
    if (tmo || chk_en_o !== 12'hFFB) begin
      errors++; $display("FAIL lock_on_en got=%h tmo=%b exp=ffb", chk_en_o, tmo);
    end
    checks++;
    if (lock_skip_o !== SKIP_ONE) begin
      errors++; $display("FAIL lock_skip got=%0d exp=%0d", lock_skip_o, SKIP_ONE);
    end
    push(CTRL_UNLOCK, 8'h01, 3'b001, 1'b0, 4'd2);
    wait_done(lat, tmo);
    push(CTRL_ON, 8'hFF, 3'b111, 1'b1, 4'd0);
    wait_done(lat, tmo);
    checks++;
    if (tmo || chk_en_o !== 12'hFFF) begin
      errors++; $display("FAIL unlock_on_en got=%h tmo=%b exp=fff", chk_en_o, tmo);
    end
    checks++;
    if (lock_skip_o !== SKIP_ONE) begin
      errors++; $display("FAIL unlock_skip got=%0d exp=%0d", lock_skip_o, SKIP_ONE);
    end
  endtask

  task automatic test_kill;
    push(CTRL_KILL, 8'h01, 3'b001, 1'b1, 4'd0);
    wait_done(lat, tmo);
    checks++;
    if (tmo || kill_acc !== 12'h007) begin
      errors++; $display("FAIL kill_mask got=%h tmo=%b exp=007", kill_acc, tmo);
    end
    checks++;
    if (kill_cnt != 3) begin
      errors++; $display("FAIL kill_width got=%0d exp=3", kill_cnt);
    end
    checks++;
    if (chk_en_o !== 12'hFFF) begin
      errors++; $display("FAIL kill_en got=%h exp=fff", chk_en_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (chk_kill_o !== 12'h000) begin
      errors++; $display("FAIL kill_clear got=%h exp=000", chk_kill_o);
    end
  endtask

  task automatic test_vacuous;
    push(CTRL_VACUOUSOFF, 8'h11, 3'b111, 1'b1, 4'd0);
    wait_done(lat, tmo);
    checks++;
    if (tmo || chk_vac_off_o !== 12'h49F) begin
      errors++; $display("FAIL vac_off got=%h tmo=%b exp=49f", chk_vac_off_o, tmo);
    end
    push(CTRL_VACUOUSON, 8'h11, 3'b111, 1'b1, 4'd0);
    wait_done(lat, tmo);
    checks++;
    if (tmo || chk_vac_off_o !== 12'h000) begin
      errors++; $display("FAIL vac_on got=%h tmo=%b exp=000", chk_vac_off_o, tmo);
    end
  endtask

  task automatic test_back_to_back;
    int ndone;
    logic idle;
    push(CTRL_OFF, 8'hFF, 3'b111, 1'b1, 4'd0);
    push(CTRL_ON, 8'h02, 3'b001, 1'b0, 4'd5);
    push(CTRL_VACUOUSOFF, 8'h02, 3'b001, 1'b0, 4'd5);
    push(CTRL_OFF, 8'h02, 3'b001, 1'b0, 4'd5);
    push(CTRL_ON, 8'h02, 3'b001, 1'b0, 4'd5);
    checks++;
    if (cmd_ready_o !== 1'b0) begin
      errors++; $display("FAIL b2b_full_ready got=%b exp=0", cmd_ready_o);
    end
    ndone = 0;
    idle  = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (done_o) ndone++;
      if (!busy_o) begin
        idle = 1'b1;
        break;
      end
    end
    checks++;
    if (!idle || ndone != 5) begin
      errors++; $display("FAIL b2b_done_count got=%0d idle=%b exp=5", ndone, idle);
    end
    checks++;
    if (chk_en_o !== 12'h020) begin
      errors++; $display("FAIL b2b_order_en got=%h exp=020", chk_en_o);
    end
    checks++;
    if (chk_vac_off_o !== 12'h020) begin
      errors++; $display("FAIL b2b_vac got=%h exp=020", chk_vac_off_o);
    end
  endtask

  task automatic test_errors;
    push(4'd7, 8'hFF, 3'b111, 1'b0, 4'd0);
    wait_done(lat, tmo);
    checks++;
    if (tmo || lat != 3 || err_o !== 1'b1) begin
      errors++; $display("FAIL err_ctrl lat=%0d err=%b tmo=%b exp lat=3 err=1", lat, err_o, tmo);
    end
    push(CTRL_ON, 8'hFF, 3'b111, 1'b0, 4'(N));
    wait_done(lat, tmo);
    checks++;
    if (tmo || err_o !== 1'b1) begin
      errors++; $display("FAIL err_id err=%b tmo=%b exp=1", err_o, tmo);
    end
    checks++;
    if (chk_en_o !== 12'h020 || chk_vac_off_o !== 12'h020) begin
      errors++; $display("FAIL err_unchanged en=%h vac=%h exp=020/020", chk_en_o, chk_vac_off_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (err_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL err_pulse err=%b done=%b exp=0/0", err_o, done_o);
    end
  endtask

  task automatic test_reset_mid_sweep;
    push(CTRL_ON, 8'hFF, 3'b111, 1'b1, 4'd0);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL mid_busy got=%b exp=1", busy_o);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0 || chk_en_o !== 12'hFFF) begin
      errors++; $display("FAIL post_rst busy=%b en=%h exp=0/fff", busy_o, chk_en_o);
    end
  endtask

  initial begin
    logic [7:0] at [N];
    logic [2:0] dt [N];
    at = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h10, 8'h02,
           8'h04, 8'h01, 8'h20, 8'h80, 8'h10, 8'h08};
    dt = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 3'b001,
           3'b100, 3'b100, 3'b001, 3'b010, 3'b010, 3'b001};
    for (int i = 0; i < N; i++) begin
      chk_atype_i[i*8 +: 8] = at[i];
      chk_dtype_i[i*3 +: 3] = dt[i];
    end
    cmd_valid_i = 1'b0;
    cmd_i       = '0;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_off_all();
    test_lock();
    test_kill();
    test_vacuous();
    test_back_to_back();
    test_errors();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
